ps2_key_tracker: RTL and testbench
==================================

# ps2_key_tracker

Receives PS/2 keyboard frames, validates them and tracks make/break (press/release) state for the synth keyboard. Produces `pressedkey` (last accepted make code) and `key1_on` (level, high while that key is held) for the pitch decoder, which latches the note on each rising edge of `key1_on`. Sits between the DE2 PS/2 pins and the pitch decoder. Every key change produces a clean rising edge.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 100000: `clk` cycles with no PS/2 falling edge before a partial frame is discarded (2 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `ps2_clk`  in  1  raw PS/2 clock; asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data; asynchronous to `clk`.
- `pressedkey`  out  8  scan code of the currently/last held key.
- `key1_on`  out  1  high while `pressedkey` is held.
- `scan_code`  out  8  last valid received byte, any type.
- `scan_valid`  out  1  one-cycle pulse when `scan_code` updates.
- `frame_err`  out  1  one-cycle pulse on a bad start, parity or stop bit, or on a timeout.

## Operation
- Input conditioning: `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer. A falling edge is synced clk 1 then 0 on consecutive cycles. Data is sampled on the edge cycle.
- Frame FSM:
  - IDLE: on a falling edge, if data is 0 (start bit), go to RECV with bitcnt=1. Otherwise stay in IDLE and pulse `frame_err`.
  - RECV: each falling edge shifts data into a 10-bit register, LSB first, and increments bitcnt.
  - When bitcnt reaches 11 (stop bit sampled), check parity and stop. Parity is odd over 8 data bits plus the parity bit; stop must be 1.
  - Good frame: load `scan_code`, pulse `scan_valid`, return to IDLE. Bad frame: pulse `frame_err`, discard the byte, return to IDLE.
- Watchdog: a counter clears on every falling edge and increments in RECV. When it reaches `TIMEOUT_CYCLES`, pulse `frame_err`, return to IDLE, and clear bitcnt. In IDLE the counter holds at 0.
- Decode FSM, advanced only on `scan_valid`:
  - States: NORM, BRK (F0 seen), EXT (E0 seen), EXTBRK (E0 F0 seen).
  - NORM: F0 goes to BRK; E0 goes to EXT; any other code is a make.
  - BRK: the code is a break; return to NORM.
  - EXT: F0 goes to EXTBRK. Any other code is ignored; return to NORM.
  - EXTBRK: the code is ignored; return to NORM.
- Make handling:
  - Same code as `pressedkey` while `key1_on`=1 is typematic repeat. No change.
  - Different code while `key1_on`=1: `pressedkey` takes the new code and `key1_on` drops for exactly one cycle, then rises (retrigger).
  - Any code while `key1_on`=0: `pressedkey` takes the new code and `key1_on` rises.
- Break handling:
  - Break of the code equal to `pressedkey`: `key1_on` goes to 0, `pressedkey` is held.
  - Break of any other code: ignored.
- Codes AA (self-test) and FA/FE (ack/resend) in NORM are ignored as makes.

## Timing
- Reset values: `pressedkey`=00, `key1_on`=0, `scan_code`=00, `scan_valid`=0, `frame_err`=0. Both FSMs reset to IDLE/NORM. Synchronizers, bitcnt, shift register and watchdog are cleared.
- Reset mid-frame abandons the frame. No pulses are produced for it.
- Stop-bit edge detected at cycle k → `scan_valid`/`frame_err` high at k+1 → decode outputs update at k+2.
- Retrigger: at k+2, `pressedkey`=new and `key1_on`=0. At k+3, `key1_on`=1. A `scan_valid` cannot arrive during this window, because frames are at least 11 PS/2 clocks apart.
- `scan_valid` and `frame_err` are never high in the same cycle.
- Latency from the raw stop-bit falling edge to `key1_on` change: 2–3 synchronizer cycles + 2.

## Test plan
- Frame 1A with parity 0, start 0, stop 1, at a 60 µs bit period → `scan_valid` pulse, `scan_code`=1A, `pressedkey`=1A, `key1_on`=1 at k+2.
- Stream 1A, 1A, 1A (typematic) then F0 1A → `key1_on` stays 1 through the repeats, falls on the break byte, `pressedkey` remains 1A.
- Hold 1A, send make 22 → `pressedkey`=22 and `key1_on`=0 for one cycle, then 1. Then send F0 1A → no change. Then send F0 22 → `key1_on`=0.
- E0 75 then E0 F0 75 with `key1_on`=0 → `scan_valid` pulses on all 5 bytes, `pressedkey`/`key1_on` unchanged.
- Frame 23 with wrong parity → `frame_err` pulse, no `scan_valid`, outputs unchanged. Then send 23 correctly → accepted.
- Send 5 bits and stop toggling `ps2_clk` → `frame_err` after `TIMEOUT_CYCLES`. The next full frame 21 is received correctly. Assert `reset` mid-frame → all outputs return to reset values.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver and key-state tracker for the synth keyboard.
// Frames are synchronised, validated (start/parity/stop, watchdog) and the
// resulting scan codes drive a make/break decoder that presents one held key
// to the pitch decoder as a code plus a level that re-rises on each key change.
module ps2_key_tracker #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] pressedkey,
    output logic       key1_on,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] CodeBreak    = 8'hF0;
    localparam logic [7:0] CodeExt      = 8'hE0;
    localparam logic [7:0] CodeSelfTest = 8'hAA;
    localparam logic [7:0] CodeAck      = 8'hFA;
    localparam logic [7:0] CodeResend   = 8'hFE;

    typedef enum logic [0:0] {FrIdle, FrRecv} frame_state_e;
    typedef enum logic [1:0] {DecNorm, DecBrk, DecExt, DecExtBrk} dec_state_e;

    logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
    logic ps2_data_meta_q, ps2_data_sync_q;
    logic ps2_fall;

    frame_state_e frame_state_q;
    logic [3:0]   bitcnt_q;
    logic [9:0]   shift_q;
    logic [9:0]   shift_next;
    logic         frame_ok;
    logic [WdW-1:0] wd_q;

    dec_state_e dec_state_q;
    logic       retrig_q;
    logic       is_ignored_make;

    // Two-flop synchronisers plus one delay stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2_clk_meta_q  <= 1'b0;
            ps2_clk_sync_q  <= 1'b0;
            ps2_clk_prev_q  <= 1'b0;
            ps2_data_meta_q <= 1'b0;
            ps2_data_sync_q <= 1'b0;
        end else begin
            ps2_clk_meta_q  <= ps2_clk;
            ps2_clk_sync_q  <= ps2_clk_meta_q;
            ps2_clk_prev_q  <= ps2_clk_sync_q;
            ps2_data_meta_q <= ps2_data;
            ps2_data_sync_q <= ps2_data_meta_q;
        end
    end

    assign ps2_fall = ps2_clk_prev_q & ~ps2_clk_sync_q;

    // Incoming bits enter at the top so the first data bit lands in bit 0.
    assign shift_next = {ps2_data_sync_q, shift_q[9:1]};
    // Odd parity over data+parity, stop bit high.
    assign frame_ok   = (^shift_next[8:0]) & shift_next[9];

    // Frame receiver with watchdog; pulses are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_state_q <= FrIdle;
            bitcnt_q      <= 4'd0;
            shift_q       <= 10'd0;
            wd_q          <= '0;
            scan_code     <= 8'h00;
            scan_valid    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (frame_state_q)
                FrIdle: begin
                    wd_q <= '0;
                    if (ps2_fall) begin
                        if (!ps2_data_sync_q) begin
                            frame_state_q <= FrRecv;
                            bitcnt_q      <= 4'd1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                FrRecv: begin
                    if (ps2_fall) begin
                        wd_q    <= '0;
                        shift_q <= shift_next;
                        // This edge carries the stop bit (count becomes 11).
                        if (bitcnt_q == 4'd10) begin
                            frame_state_q <= FrIdle;
                            bitcnt_q      <= 4'd0;
                            if (frame_ok) begin
                                scan_code  <= shift_next[7:0];
                                scan_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end
                    end else if (wd_q == WdW'(TIMEOUT_CYCLES)) begin
                        frame_err     <= 1'b1;
                        frame_state_q <= FrIdle;
                        bitcnt_q      <= 4'd0;
                        wd_q          <= '0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: frame_state_q <= FrIdle;
            endcase
        end
    end

    assign is_ignored_make = (scan_code == CodeSelfTest) || (scan_code == CodeAck) ||
                             (scan_code == CodeResend);

    // Make/break decoder; a key change drops key1_on for one cycle to retrigger.
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_state_q <= DecNorm;
            pressedkey  <= 8'h00;
            key1_on     <= 1'b0;
            retrig_q    <= 1'b0;
        end else begin
            if (retrig_q) begin
                key1_on  <= 1'b1;
                retrig_q <= 1'b0;
            end
            if (scan_valid) begin
                case (dec_state_q)
                    DecNorm: begin
                        if (scan_code == CodeBreak) begin
                            dec_state_q <= DecBrk;
                        end else if (scan_code == CodeExt) begin
                            dec_state_q <= DecExt;
                        end else if (!is_ignored_make) begin
                            if (!key1_on) begin
                                pressedkey <= scan_code;
                                key1_on    <= 1'b1;
                            end else if (scan_code != pressedkey) begin
                                pressedkey <= scan_code;
                                key1_on    <= 1'b0;
                                retrig_q   <= 1'b1;
                            end
                        end
                    end
                    DecBrk: begin
                        if (scan_code == pressedkey) begin
                            key1_on <= 1'b0;
                        end
                        dec_state_q <= DecNorm;
                    end
                    DecExt: begin
                        dec_state_q <= (scan_code == CodeBreak) ? DecExtBrk : DecNorm;
                    end
                    DecExtBrk: dec_state_q <= DecNorm;
                    default:   dec_state_q <= DecNorm;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker with a scaled-down PS/2 bit period.
module tb_ps2_key_tracker;

    localparam int unsigned TIMEOUT = 200;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] pressedkey;
    logic       key1_on;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    int n_run = 0;
    int n_fail = 0;

    int cyc = 0, sv_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int rise_cnt = 0, fall_cnt = 0, sv_cyc = 0, rise_cyc = 0;
    int low_run = 0, low_len = 0;
    logic k1_prev = 1'b0;

    int sv0, fe0, r0;

    ps2_key_tracker #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .pressedkey (pressedkey),
        .key1_on    (key1_on),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Event monitor: pulse counts, key1_on edges and low-run lengths.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (scan_valid) begin
            sv_cnt <= sv_cnt + 1;
            sv_cyc <= cyc;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (scan_valid && frame_err) both_cnt <= both_cnt + 1;
        if (key1_on && !k1_prev) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
            low_len  <= low_run;
        end
        if (!key1_on && k1_prev) fall_cnt <= fall_cnt + 1;
        low_run <= key1_on ? 0 : low_run + 1;
        k1_prev <= key1_on;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run = n_run + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par);
        logic [10:0] fr;
        fr = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(fr[i]);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_partial();
        logic [4:0] bits;
        bits = 5'b10110;  // start bit 0 first
        for (int i = 0; i < 5; i++) ps2_bit(bits[i]);
        ps2_data = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_pressedkey", pressedkey, 8'h00);
        check("rst_key1_on", key1_on, 0);
        check("rst_scan_code", scan_code, 8'h00);
        check("rst_scan_valid", scan_valid, 0);
        check("rst_frame_err", frame_err, 0);

        // Single make 1A.
        send_frame(8'h1A, 1'b0);
        check("t1_scan_code", scan_code, 8'h1A);
        check("t1_pressedkey", pressedkey, 8'h1A);
        check("t1_key1_on", key1_on, 1);
        check("t1_sv_cnt", sv_cnt, 1);
        check("t1_latency", rise_cyc - sv_cyc, 1);

        // Typematic repeats, then break.
        repeat (3) send_frame(8'h1A, 1'b0);
        check("t2_rep_key1_on", key1_on, 1);
        check("t2_rep_rises", rise_cnt, 1);
        check("t2_rep_falls", fall_cnt, 0);
        send_frame(8'hF0, 1'b0);
        check("t2_f0_key1_on", key1_on, 1);
        send_frame(8'h1A, 1'b0);
        check("t2_brk_key1_on", key1_on, 0);
        check("t2_brk_pressedkey", pressedkey, 8'h1A);
        check("t2_brk_falls", fall_cnt, 1);

        // Retrigger on a new key while one is held.
        send_frame(8'h1A, 1'b0);
        check("t3_hold_key1_on", key1_on, 1);
        r0 = rise_cnt;
        send_frame(8'h22, 1'b0);
        check("t3_new_pressedkey", pressedkey, 8'h22);
        check("t3_new_key1_on", key1_on, 1);
        check("t3_low_len", low_len, 1);
        check("t3_rises", rise_cnt, r0 + 1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1A, 1'b0);
        check("t3_oldbrk_key1_on", key1_on, 1);
        check("t3_oldbrk_pressedkey", pressedkey, 8'h22);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h22, 1'b0);
        check("t3_brk_key1_on", key1_on, 0);

        // Extended make/break and self-test code are ignored.
        sv0 = sv_cnt;
        r0  = rise_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("t4_sv_cnt", sv_cnt, sv0 + 5);
        check("t4_scan_code", scan_code, 8'h75);
        check("t4_pressedkey", pressedkey, 8'h22);
        check("t4_key1_on", key1_on, 0);
        send_frame(8'hAA, 1'b0);
        check("t4_aa_key1_on", key1_on, 0);
        check("t4_aa_pressedkey", pressedkey, 8'h22);
        check("t4_rises", rise_cnt, r0);

        // Parity error, then the same byte correctly.
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h23, 1'b1);
        check("t5_fe_cnt", fe_cnt, fe0 + 1);
        check("t5_sv_cnt", sv_cnt, sv0);
        check("t5_scan_code", scan_code, 8'hAA);
        check("t5_key1_on", key1_on, 0);
        send_frame(8'h23, 1'b0);
        check("t5_ok_scan_code", scan_code, 8'h23);
        check("t5_ok_pressedkey", pressedkey, 8'h23);
        check("t5_ok_key1_on", key1_on, 1);

        // Partial frame times out; next frame still decodes.
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_partial();
        repeat (TIMEOUT + 50) @(negedge clk);
        check("t6_timeout_fe", fe_cnt, fe0 + 1);
        check("t6_timeout_sv", sv_cnt, sv0);
        send_frame(8'h21, 1'b0);
        check("t6_scan_code", scan_code, 8'h21);
        check("t6_pressedkey", pressedkey, 8'h21);
        check("t6_low_len", low_len, 1);
        check("t6_key1_on", key1_on, 1);

        // Reset mid-frame abandons it without pulses.
        send_partial();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        @(negedge clk);
        check("t7_pressedkey", pressedkey, 8'h00);
        check("t7_key1_on", key1_on, 0);
        check("t7_scan_code", scan_code, 8'h00);
        repeat (TIMEOUT + 50) @(negedge clk);
        check("t7_fe_cnt", fe_cnt, fe0);
        check("t7_sv_cnt", sv_cnt, sv0);
        check("never_both", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
